// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero/one counter and left-normaliser with valid/ready flow control.
// S1 holds the operand plus its count and zero flag; S2 holds the shifted result.
module lzc_norm_pipe #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_invert,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_norm,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  if (WIDTH < 8 || WIDTH > 128 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("lzc_norm_pipe: WIDTH must be a power of two in 8..128");
  end

  logic [WIDTH-1:0] eff;
  assign eff = in_invert ? ~in_data : in_data;

  // Level gi holds WIDTH>>gi nodes, each covering 2**gi bits with a gi-bit count.
  for (genvar gi = 1; gi <= CW; gi++) begin : g_lvl
    localparam int N = WIDTH >> gi;
    logic [N-1:0]    v;
    logic [N*gi-1:0] c;
    for (genvar gj = 0; gj < N; gj++) begin : g_node
      if (gi == 1) begin : g_leaf
        assign v[gj] = eff[2*gj+1] | eff[2*gj];
        assign c[gj] = ~eff[2*gj+1];
      end else begin : g_merge
        logic          vh, vl;
        logic [gi-2:0] ch, cl;
        assign vh = g_lvl[gi-1].v[2*gj+1];
        assign vl = g_lvl[gi-1].v[2*gj];
        assign ch = g_lvl[gi-1].c[(2*gj+1)*(gi-1) +: (gi-1)];
        assign cl = g_lvl[gi-1].c[(2*gj)*(gi-1) +: (gi-1)];
        assign v[gj] = vh | vl;
        assign c[gj*gi +: gi] = vh ? {1'b0, ch} : {1'b1, cl};
      end
    end
  end

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [CW-1:0]    s1_count_q, s1_count_d;
  logic             s1_zero_q, s1_zero_d;
  logic [TAG_W-1:0] s1_tag_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_norm_q, out_norm_d;
  logic [CW-1:0]    out_count_q;
  logic             out_zero_q;
  logic [TAG_W-1:0] out_tag_q;

  logic s2_free, s1_adv, in_fire;

  // An all-zero operand reports count 0 so that S2 passes it through unshifted.
  assign s1_zero_d  = ~g_lvl[CW].v[0];
  assign s1_count_d = s1_zero_d ? '0 : g_lvl[CW].c;
  assign out_norm_d = s1_data_q << s1_count_q;

  assign s2_free  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_count_q  <= '0;
      s1_zero_q   <= 1'b0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_norm_q  <= '0;
      out_count_q <= '0;
      out_zero_q  <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= in_data;
        s1_count_q <= s1_count_d;
        s1_zero_q  <= s1_zero_d;
        s1_tag_q   <= in_tag;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_free) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_norm_q  <= out_norm_d;
          out_count_q <= s1_count_q;
          out_zero_q  <= s1_zero_q;
          out_tag_q   <= s1_tag_q;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_norm  = out_norm_q;
  assign out_count = out_count_q;
  assign out_zero  = out_zero_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Directed bench for lzc_norm_pipe: latency, ordering, stalls, reset and a width sweep.
module tb_lzc_norm_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_invert = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_zero;
  logic [63:0] in_data = '0, out_norm;
  logic [5:0]  out_count;
  logic [3:0]  in_tag = '0, out_tag;

  lzc_norm_pipe #(.WIDTH(64), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_invert(in_invert), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_norm(out_norm), .out_count(out_count), .out_zero(out_zero), .out_tag(out_tag));

  // Width sweep instances share one stimulus vector.
  logic [2:0]   sw_valid = '0;
  logic [127:0] sw_data = '0;
  logic         r8, r32, r128, v8, v32, v128, z8, z32, z128;
  logic [7:0]   n8;
  logic [31:0]  n32;
  logic [127:0] n128;
  logic [2:0]   c8;
  logic [4:0]   c32;
  logic [6:0]   c128;
  logic [3:0]   t8, t32, t128;

  lzc_norm_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid[0]), .in_ready(r8), .in_data(sw_data[7:0]),
    .in_invert(1'b0), .in_tag(4'd0), .out_valid(v8), .out_ready(1'b1),
    .out_norm(n8), .out_count(c8), .out_zero(z8), .out_tag(t8));
  lzc_norm_pipe #(.WIDTH(32), .TAG_W(4)) u32 (
    .clk(clk), .rst(rst), .in_valid(sw_valid[1]), .in_ready(r32), .in_data(sw_data[31:0]),
    .in_invert(1'b0), .in_tag(4'd0), .out_valid(v32), .out_ready(1'b1),
    .out_norm(n32), .out_count(c32), .out_zero(z32), .out_tag(t32));
  lzc_norm_pipe #(.WIDTH(128), .TAG_W(4)) u128 (
    .clk(clk), .rst(rst), .in_valid(sw_valid[2]), .in_ready(r128), .in_data(sw_data),
    .in_invert(1'b0), .in_tag(4'd0), .out_valid(v128), .out_ready(1'b1),
    .out_norm(n128), .out_count(c128), .out_zero(z128), .out_tag(t128));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] norm;
    logic [5:0]  cnt;
    logic        z;
    logic [3:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  // Occupancy model: both stages are full exactly when two operands are in flight.
  int inflight = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) inflight <= 0;
    else inflight <= inflight + int'(in_valid && in_ready) - int'(out_valid && out_ready);
  end

  logic        stall_pend = 1'b0;
  logic [63:0] sn;
  logic [5:0]  sc;
  logic        sz;
  logic [3:0]  st;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(inflight == 2 && !out_ready));
      if (stall_pend) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_norm", out_norm, sn);
        chk("stall_count", out_count, sc);
        chk("stall_zero", out_zero, sz);
        chk("stall_tag", out_tag, st);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("out tag=%0d count=%0d zero=%0d norm=%h", out_tag, out_count, out_zero, out_norm);
          chk("out_norm", out_norm, e.norm);
          chk("out_count", out_count, e.cnt);
          chk("out_zero", out_zero, e.z);
          chk("out_tag", out_tag, e.tag);
        end
      end
      stall_pend = out_valid && !out_ready;
      sn = out_norm; sc = out_count; sz = out_zero; st = out_tag;
    end
  end

  // Called and returns at posedge+1; holds the operand until accepted.
  task automatic send(input logic [63:0] d, input logic inv, input logic [3:0] tg,
                      input logic [63:0] en, input logic [5:0] ec, input logic ez);
    int n = 0;
    exp_t x;
    in_valid = 1'b1; in_data = d; in_invert = inv; in_tag = tg;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    x.norm = en; x.cnt = ec; x.z = ez; x.tag = tg;
    exp_q.push_back(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    #1;
  endtask

  logic stream_on = 1'b0;
  exp_t x0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_norm", out_norm, 0);
    chk("rst_count", out_count, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_tag", out_tag, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", in_ready, 1);

    // Single operand, latency check
    x0.norm = 64'h8000_0000_0000_0000; x0.cnt = 6'd47; x0.z = 1'b0; x0.tag = 4'd1;
    exp_q.push_back(x0);
    in_valid = 1'b1; in_data = 64'h0000_0000_0001_0000; in_invert = 1'b0; in_tag = 4'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_cycle1", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_cycle2", out_valid, 1);
    chk("lat_count", out_count, 47);
    drain();

    // Zero, MSB-only and all-ones operands, then invert mode
    send(64'h0, 1'b0, 4'd2, 64'h0, 6'd0, 1'b1);
    send(64'h8000_0000_0000_0000, 1'b0, 4'd3, 64'h8000_0000_0000_0000, 6'd0, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 1'b0);
    send(64'hFFF0_0000_0000_0000, 1'b1, 4'd5, 64'h0, 6'd12, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 1'b1);
    drain();

    // Eight tagged operands with out_ready cycling 1,0,0
    stream_on = 1'b1;
    fork
      begin
        int k = 0;
        while (stream_on) begin
          out_ready = (k % 3 == 0);
          @(posedge clk); #1;
          k++;
        end
      end
      begin
        for (int t = 0; t < 8; t++)
          send(64'h1 << (9 * t), 1'b0, 4'(t), 64'h8000_0000_0000_0000, 6'(63 - 9 * t), 1'b0);
        drain();
        stream_on = 1'b0;
      end
    join
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Fill both stages, then reset mid-flight
    out_ready = 1'b0;
    send(64'h0000_0000_0000_0100, 1'b0, 4'd9, 64'h8000_0000_0000_0000, 6'd55, 1'b0);
    send(64'h0000_0000_0000_0200, 1'b0, 4'd10, 64'h8000_0000_0000_0000, 6'd54, 1'b0);
    chk("full_ready", in_ready, 0);
    chk("full_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", out_valid, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("no_stale_valid", out_valid, 0);
    chk("post_rst_ready", in_ready, 1);
    x0.norm = 64'hF000_0000_0000_0000; x0.cnt = 6'd56; x0.z = 1'b0; x0.tag = 4'd11;
    exp_q.push_back(x0);
    in_valid = 1'b1; in_data = 64'h0000_0000_0000_00F0; in_invert = 1'b0; in_tag = 4'd11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_rst_lat1", out_valid, 0);
    @(posedge clk); #1;
    chk("post_rst_lat2", out_valid, 1);
    drain();

    // Single set bit at every position for WIDTH 8, 32 and 128
    for (int p = 0; p < 128; p++) begin
      sw_data = 128'h1 << p;
      sw_valid = {1'b1, p < 32, p < 8};
      @(posedge clk); #1;
      sw_valid = '0;
      @(posedge clk); #1;
      if (p < 8) begin
        chk("w8_valid", v8, 1);
        chk("w8_count", c8, 7 - p);
        chk("w8_norm", n8, 8'h80);
        chk("w8_zero", z8, 0);
      end
      if (p < 32) begin
        chk("w32_valid", v32, 1);
        chk("w32_count", c32, 31 - p);
        chk("w32_norm", n32, 32'h8000_0000);
        chk("w32_zero", z32, 0);
      end
      chk("w128_valid", v128, 1);
      chk("w128_count", c128, 127 - p);
      chk("w128_norm", n128, 128'h1 << 127);
      chk("w128_zero", z128, 0);
    end
    $display("sweep done: positions 0..127");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
